// File: rtl/contador_pkg.sv
// Shared types, range presets and the binary-to-BCD helper for the modulo counter.
package contador_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDelay,
      StRepeat
   } repeat_state_e;

   localparam int unsigned HOURS_24_MIN = 0;
   localparam int unsigned HOURS_24_MAX = 23;
   localparam int unsigned HOURS_12_MIN = 1;
   localparam int unsigned HOURS_12_MAX = 12;
   localparam int unsigned MIN_SEC_MIN  = 0;
   localparam int unsigned MIN_SEC_MAX  = 59;

   // Returns {tens, units}; only meaningful for values up to 99.
   function automatic logic [7:0] to_bcd(input int unsigned value);
      int unsigned tens;
      int unsigned units;
      tens  = value / 10;
      units = value % 10;
      return {4'(tens), 4'(units)};
   endfunction

endpackage

// File: rtl/modif_repeat.sv
// Press-and-hold auto-repeat for one adjust button: one step on press, one after
// REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles while still held.
module modif_repeat
   import contador_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 25000000,
   parameter int unsigned REPEAT_PERIOD = 5000000,
   parameter int unsigned RPT_W         = 25
) (
   input  logic clock,
   input  logic reset,
   input  logic boton,
   output logic paso
);

   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   repeat_state_e    r_state;
   logic [RPT_W-1:0] r_timer;
   logic             w_delay_done;
   logic             w_period_done;

   assign w_delay_done  = (r_timer == DELAY_LAST);
   assign w_period_done = (r_timer == PERIOD_LAST);

   // Strobe is combinational so the count moves on the edge that first samples the press.
   always_comb begin
      paso = 1'b0;
      unique case (r_state)
         StIdle:   paso = boton;
         StDelay:  paso = boton && w_delay_done;
         StRepeat: paso = boton && w_period_done;
         default:  paso = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= StIdle;
         r_timer <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_timer <= '0;
               if (boton) r_state <= StDelay;
            end
            StDelay: begin
               if (!boton) begin
                  r_state <= StIdle;
                  r_timer <= '0;
               end else if (w_delay_done) begin
                  r_state <= StRepeat;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + RPT_W'(1);
               end
            end
            StRepeat: begin
               if (!boton) begin
                  r_state <= StIdle;
                  r_timer <= '0;
               end else if (w_period_done) begin
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + RPT_W'(1);
               end
            end
            default: begin
               r_state <= StIdle;
               r_timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/contador_modulo_param.sv
// Range-limited chainable counter (hours/minutes/seconds) with tick carry, manual
// up/down adjust with auto-repeat, range-checked load and BCD digit outputs.
module contador_modulo_param
   import contador_pkg::*;
#(
   parameter int unsigned WIDTH         = 5,
   parameter int unsigned MIN_VALUE     = 0,
   parameter int unsigned MAX_VALUE     = 23,
   parameter int unsigned INIT_VALUE    = 23,
   parameter int unsigned REPEAT_DELAY  = 25000000,
   parameter int unsigned REPEAT_PERIOD = 5000000,
   parameter int unsigned RPT_W         = 25
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick,
   input  logic             modifInc,
   input  logic             modifDec,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   output logic [WIDTH-1:0] contador,
   output logic             carry,
   output logic [3:0]       decenas,
   output logic [3:0]       unidades
);

   localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VALUE);
   localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VALUE);

   logic             w_inc;
   logic             w_dec;
   logic             w_below_min;
   logic             w_load_ok;
   logic [WIDTH-1:0] w_contador_next;
   logic             w_carry_next;
   logic [WIDTH-1:0] r_contador;
   logic             r_carry;
   logic [7:0]       w_bcd;

   modif_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .RPT_W        (RPT_W)
   ) u_rep_inc (
      .clock(clock),
      .reset(reset),
      .boton(modifInc),
      .paso (w_inc)
   );

   modif_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .RPT_W        (RPT_W)
   ) u_rep_dec (
      .clock(clock),
      .reset(reset),
      .boton(modifDec),
      .paso (w_dec)
   );

   // A zero lower bound makes the below-range compare vacuous, so it is not built.
   if (MIN_VALUE == 0) begin : g_min_zero
      assign w_below_min = 1'b0;
   end else begin : g_min_nonzero
      assign w_below_min = (loadValue < MIN_W);
   end

   assign w_load_ok = !w_below_min && (loadValue <= MAX_W);

   always_comb begin
      w_contador_next = r_contador;
      w_carry_next    = 1'b0;
      if (load) begin
         if (w_load_ok) w_contador_next = loadValue;
      end else if (w_inc || w_dec) begin
         // Simultaneous inc and dec cancel; any manual strobe swallows the tick.
         if (w_inc && !w_dec) begin
            w_contador_next = (r_contador == MAX_W) ? MIN_W : r_contador + WIDTH'(1);
         end else if (w_dec && !w_inc) begin
            w_contador_next = (r_contador == MIN_W) ? MAX_W : r_contador - WIDTH'(1);
         end
      end else if (tick) begin
         if (r_contador == MAX_W) begin
            w_contador_next = MIN_W;
            w_carry_next    = 1'b1;
         end else begin
            w_contador_next = r_contador + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_contador <= INIT_W;
         r_carry    <= 1'b0;
      end else begin
         r_contador <= w_contador_next;
         r_carry    <= w_carry_next;
      end
   end

   assign w_bcd    = to_bcd(32'(r_contador));
   assign contador = r_contador;
   assign carry    = r_carry;
   assign decenas  = w_bcd[7:4];
   assign unidades = w_bcd[3:0];

endmodule

// File: tb/tb_contador_modulo_param.sv
// Checks a 24h (0..23) and a 12h (1..12) counter against a behavioural model every
// cycle, plus directed literal expectations from hand-worked sequences.
module tb_contador_modulo_param;

   localparam int D = 4;
   localparam int P = 2;

   logic       clk = 1'b0;
   logic       rst_a, tick_a, inc_a, dec_a, ld_a;
   logic [4:0] lv_a, cnt_a;
   logic       car_a;
   logic [3:0] dec_dig_a, uni_a;
   logic       rst_b, tick_b, inc_b, dec_b, ld_b;
   logic [4:0] lv_b, cnt_b;
   logic       car_b;
   logic [3:0] dec_dig_b, uni_b;

   int n_checks = 0;
   int n_err    = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   contador_modulo_param #(
      .WIDTH(5), .MIN_VALUE(0), .MAX_VALUE(23), .INIT_VALUE(23),
      .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .RPT_W(3)
   ) dut_a (
      .clock(clk), .reset(rst_a), .tick(tick_a), .modifInc(inc_a), .modifDec(dec_a),
      .load(ld_a), .loadValue(lv_a), .contador(cnt_a), .carry(car_a),
      .decenas(dec_dig_a), .unidades(uni_a)
   );

   contador_modulo_param #(
      .WIDTH(5), .MIN_VALUE(1), .MAX_VALUE(12), .INIT_VALUE(12),
      .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .RPT_W(3)
   ) dut_b (
      .clock(clk), .reset(rst_b), .tick(tick_b), .modifInc(inc_b), .modifDec(dec_b),
      .load(ld_b), .loadValue(lv_b), .contador(cnt_b), .carry(car_b),
      .decenas(dec_dig_b), .unidades(uni_b)
   );

   task automatic check_val(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // h = number of earlier consecutive cycles the button was already held.
   function automatic bit strobe_now(input bit btn, input int h);
      return btn && (h == 0 || h == D || (h > D && (h - D) % P == 0));
   endfunction

   function automatic int next_h(input bit rst, input bit btn, input int h);
      return (rst || !btn) ? 0 : h + 1;
   endfunction

   function automatic void model_step(input int cnt, input int lo, input int hi, input int init,
                                      input bit rst, input bit ld, input int lv, input bit si,
                                      input bit sd, input bit tk, output int ncnt,
                                      output bit ncar);
      int span;
      span = hi - lo + 1;
      ncnt = cnt;
      ncar = 1'b0;
      if (rst) ncnt = init;
      else if (ld) begin
         if (lv >= lo && lv <= hi) ncnt = lv;
      end else if (si || sd) begin
         if (si && !sd) ncnt = lo + (cnt - lo + 1) % span;
         else if (sd && !si) ncnt = lo + (cnt - lo + span - 1) % span;
      end else if (tk) begin
         ncnt = lo + (cnt - lo + 1) % span;
         ncar = (cnt == hi);
      end
   endfunction

   int m_a = 23, hi_a = 0, hd_a = 0;
   bit mc_a = 1'b0;
   int m_b = 12, hi_b = 0, hd_b = 0;
   bit mc_b = 1'b0;

   always @(posedge clk) begin : mdl_a
      int nc;
      bit ncar;
      model_step(m_a, 0, 23, 23, rst_a, ld_a, int'(lv_a), strobe_now(inc_a, hi_a),
                 strobe_now(dec_a, hd_a), tick_a, nc, ncar);
      m_a  <= nc;
      mc_a <= ncar;
      hi_a <= next_h(rst_a, inc_a, hi_a);
      hd_a <= next_h(rst_a, dec_a, hd_a);
   end

   always @(posedge clk) begin : mdl_b
      int nc;
      bit ncar;
      model_step(m_b, 1, 12, 12, rst_b, ld_b, int'(lv_b), strobe_now(inc_b, hi_b),
                 strobe_now(dec_b, hd_b), tick_b, nc, ncar);
      m_b  <= nc;
      mc_b <= ncar;
      hi_b <= next_h(rst_b, inc_b, hi_b);
      hd_b <= next_h(rst_b, dec_b, hd_b);
   end

   always @(negedge clk) begin
      if (check_en) begin
         check_val("a.contador", int'(cnt_a), m_a);
         check_val("a.carry", int'(car_a), int'(mc_a));
         check_val("a.decenas", int'(dec_dig_a), m_a / 10);
         check_val("a.unidades", int'(uni_a), m_a % 10);
         check_val("b.contador", int'(cnt_b), m_b);
         check_val("b.carry", int'(car_b), int'(mc_b));
         check_val("b.decenas", int'(dec_dig_b), m_b / 10);
         check_val("b.unidades", int'(uni_b), m_b % 10);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic load_a(input int v);
      ld_a = 1'b1;
      lv_a = 5'(v);
      cyc();
      ld_a = 1'b0;
   endtask

   int exp_hold [10] = '{23, 23, 23, 23, 0, 0, 1, 1, 2, 2};

   initial begin
      {tick_a, inc_a, dec_a, ld_a} = '0;
      {tick_b, inc_b, dec_b, ld_b} = '0;
      lv_a  = '0;
      lv_b  = '0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (2) cyc();
      check_val("reset a.contador", int'(cnt_a), 23);
      check_val("reset a.carry", int'(car_a), 0);
      check_val("reset a.decenas", int'(dec_dig_a), 2);
      check_val("reset a.unidades", int'(uni_a), 3);
      check_val("reset b.contador", int'(cnt_b), 12);
      check_en = 1'b1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      cyc();

      // Tick wrap and carry
      tick_a = 1'b1;
      cyc();
      tick_a = 1'b0;
      check_val("wrap contador", int'(cnt_a), 0);
      check_val("wrap carry", int'(car_a), 1);
      cyc();
      check_val("carry one cycle", int'(car_a), 0);
      tick_a = 1'b1;
      repeat (23) cyc();
      tick_a = 1'b0;
      check_val("23 ticks contador", int'(cnt_a), 23);
      check_val("23 ticks carry", int'(car_a), 0);
      tick_a = 1'b1;
      cyc();
      tick_a = 1'b0;
      check_val("second wrap carry", int'(car_a), 1);
      check_val("second wrap contador", int'(cnt_a), 0);

      // Press-and-hold from 22
      load_a(22);
      check_val("load 22", int'(cnt_a), 22);
      inc_a = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check_val($sformatf("hold step %0d", i), int'(cnt_a), exp_hold[i]);
         if (i == 4) check_val("manual wrap carry", int'(car_a), 0);
      end
      inc_a = 1'b0;
      repeat (3) cyc();
      check_val("release holds", int'(cnt_a), 2);

      // Conflicts
      load_a(5);
      inc_a = 1'b1;
      dec_a = 1'b1;
      cyc();
      inc_a = 1'b0;
      dec_a = 1'b0;
      check_val("inc+dec cancel", int'(cnt_a), 5);
      cyc();
      tick_a = 1'b1;
      dec_a  = 1'b1;
      cyc();
      tick_a = 1'b0;
      dec_a  = 1'b0;
      check_val("dec over tick", int'(cnt_a), 4);
      check_val("dec over tick carry", int'(car_a), 0);
      cyc();

      // Load
      load_a(17);
      check_val("load 17", int'(cnt_a), 17);
      check_val("load 17 decenas", int'(dec_dig_a), 1);
      check_val("load 17 unidades", int'(uni_a), 7);
      load_a(30);
      check_val("load 30 ignored", int'(cnt_a), 17);
      load_a(24);
      check_val("load 24 ignored", int'(cnt_a), 17);
      tick_a = 1'b1;
      load_a(17);
      tick_a = 1'b0;
      check_val("load beats tick", int'(cnt_a), 17);
      load_a(0);
      check_val("load min", int'(cnt_a), 0);
      dec_a = 1'b1;
      cyc();
      dec_a = 1'b0;
      check_val("dec wrap to max", int'(cnt_a), 23);
      cyc();

      // 12h instance
      tick_b = 1'b1;
      cyc();
      tick_b = 1'b0;
      check_val("12h wrap contador", int'(cnt_b), 1);
      check_val("12h wrap carry", int'(car_b), 1);
      dec_b = 1'b1;
      cyc();
      dec_b = 1'b0;
      check_val("12h dec wrap", int'(cnt_b), 12);
      cyc();
      inc_b = 1'b1;
      repeat (8) cyc();
      check_val("12h in repeat", int'(cnt_b), 3);
      rst_b = 1'b1;
      cyc();
      check_val("12h reset mid-repeat", int'(cnt_b), 12);
      rst_b = 1'b0;
      inc_b = 1'b0;
      repeat (6) cyc();
      check_val("12h idle after reset", int'(cnt_b), 12);
      inc_b = 1'b1;
      cyc();
      inc_b = 1'b0;
      check_val("12h re-press", int'(cnt_b), 1);
      repeat (2) cyc();

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
